instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, default 24'h000000, byte address of first fetched instruction; bits [1:0] SHALL be 0.
REQ-002 Parameter: ADDR_WIDTH, default 24, width of all byte addresses (2^24-byte instruction ROM).
REQ-003 Port: clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_in  input  1  reset, synchronous, active-high.
REQ-005 Port: rom_addr_out  output  ADDR_WIDTH  byte address to instruction ROM (word-aligned).
REQ-006 Port: rom_data_in  input  32  combinational ROM read data for rom_addr_out, valid same cycle.
REQ-007 Port: redirect_valid_in  input  1  branch/jump redirect request, one-cycle pulse.
REQ-008 Port: redirect_pc_in  input  ADDR_WIDTH  redirect target byte address.
REQ-009 Port: instr_out  output  32  fetched instruction word to decode.
REQ-010 Port: pc_out  output  ADDR_WIDTH  byte address of instr_out.
REQ-011 Port: instr_valid_out  output  1  instr_out/pc_out hold a valid instruction.
REQ-012 Port: instr_ready_in  input  1  decode accepts instr_out this cycle.
REQ-013 Port: misalign_err_out  output  1  sticky flag, redirect target not word-aligned.
REQ-014 Port: fetch_count_out  output  32  number of completed decode handshakes.

Function
REQ-015 Internal PC register pc_q; rom_addr_out SHALL equal pc_q combinationally at all times.
REQ-016 FSM states: START, FETCH, ERROR; START -> FETCH unconditionally after one cycle; FETCH -> ERROR on misaligned redirect; ERROR left only by reset.
REQ-017 Output slot: single register (instr_q, pcout_q, valid_q) driving instr_out, pc_out, instr_valid_out.
REQ-018 Handshake: transfer occurs when instr_valid_out && instr_ready_in at a rising edge.
REQ-019 Load condition: state==FETCH && !redirect_valid_in && (!valid_q || instr_ready_in).
REQ-020 On load: instr_q <= rom_data_in, pcout_q <= pc_q, valid_q <= 1, pc_q <= pc_q + 4.
REQ-021 Transfer without load: valid_q <= 0.
REQ-022 Stall: while instr_valid_out && !instr_ready_in, instr_out, pc_out and pc_q SHALL stay unchanged.
REQ-023 Throughput: with instr_ready_in held 1, one instruction per cycle, consecutive pc_out values differing by 4.
REQ-024 PC arithmetic modulo 2^ADDR_WIDTH: 24'hFFFFFC + 4 -> 24'h000000, no error.
REQ-025 Redirect in FETCH (priority over load): valid_q <= 0 (flush), pc_q <= redirect_pc_in; first post-redirect instruction valid one cycle later.
REQ-026 Redirect coincident with a transfer: the transfer counts (fetch_count_out increments), the slot is then flushed.
REQ-027 Redirect with redirect_pc_in[1:0] != 0: pc_q unchanged, valid_q <= 0, misalign_err_out <= 1, state -> ERROR.
REQ-028 ERROR: no loads, redirects ignored, instr_valid_out held 0, misalign_err_out held 1.
REQ-029 Redirect in START: pc_q <= redirect_pc_in (misaligned -> ERROR), FSM still goes to FETCH otherwise.
REQ-030 fetch_count_out increments by 1 on each transfer, wraps 32'hFFFFFFFF -> 0.

Reset
REQ-031 When rst_in is 1 at a rising edge: pc_q <= RESET_PC, valid_q <= 0, instr_q <= 32'h0, pcout_q <= 0, misalign_err_out <= 0, fetch_count_out <= 0, state <= START; overrides all other inputs.
REQ-032 Reset mid-operation (including in ERROR or during stall) discards the held instruction with no transfer counted.
REQ-033 First instr_valid_out = 1 at the second rising edge after rst_in deasserts, with pc_out = RESET_PC.

Verification
REQ-034 Bench ROM model: rom_data_in = {8'hA5, rom_addr_out}; checker compares instr_out[23:0] with pc_out.
REQ-035 Reset, ready=1 for 6 cycles -> pc_out 0,4,8,12,16,20 on consecutive cycles, fetch_count_out = 6.
REQ-036 ready=0 for 3 cycles after first valid -> instr_out = 32'hA5000000, pc_out = 0 held stable, rom_addr_out = 4 held; ready=1 -> pc_out 4 next.
REQ-037 Redirect to 24'h000100 while valid slot pc 8 -> next cycle valid 0, then pc_out = 24'h000100, 24'h000104.
REQ-038 Redirect to 24'h000102 -> misalign_err_out = 1, instr_valid_out = 0 forever; later redirect to 24'h000200 ignored; rst_in pulse clears error, pc_out = RESET_PC.
REQ-039 Redirect to 24'hFFFFF8, ready=1 -> pc_out 24'hFFFFF8, 24'hFFFFFC, 24'h000000, misalign_err_out = 0.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch
//   Instruction fetch stage with a single-entry output slot toward decode.
//   A PC register addresses a combinational instruction ROM. Each accepted
//   slot is refilled from the ROM and the PC advances by 4. A redirect
//   flushes the slot and reloads the PC. A misaligned redirect target locks
//   the unit into ERROR until reset.
//
// Ports
//   clk_in             single clock, rising edge
//   rst_in             synchronous active-high reset
//   rom_addr_out       byte address presented to the ROM (always pc_q)
//   rom_data_in        ROM read data for rom_addr_out, same cycle
//   redirect_valid_in  one-cycle branch/jump redirect request
//   redirect_pc_in     redirect target byte address
//   instr_out          instruction word held in the output slot
//   pc_out             byte address of instr_out
//   instr_valid_out    output slot holds a valid instruction
//   instr_ready_in     decode accepts the slot this cycle
//   misalign_err_out   sticky flag set by a misaligned redirect target
//   fetch_count_out    number of completed decode handshakes (wraps)

module instr_fetch #(
  parameter int                    ADDR_WIDTH = 24,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  output logic [ADDR_WIDTH-1:0] rom_addr_out,
  input  logic [31:0]           rom_data_in,
  input  logic                  redirect_valid_in,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_in,
  output logic [31:0]           instr_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  instr_valid_out,
  input  logic                  instr_ready_in,
  output logic                  misalign_err_out,
  output logic [31:0]           fetch_count_out
);

  typedef enum logic [1:0] {
    START,
    FETCH,
    ERROR
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pcout_q;
  logic [31:0]           instr_q;
  logic                  valid_q;
  logic                  err_q;
  logic [31:0]           count_q;

  logic transfer;
  logic redirect_ok;
  logic redirect_bad;
  logic do_load;

  // State register: reset always returns the unit to START.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= START;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: START lasts exactly one cycle. A misaligned redirect
  // in START or FETCH enters ERROR, which only reset can leave.
  always_comb begin
    state_d = state_q;
    case (state_q)
      START:   state_d = redirect_bad ? ERROR : FETCH;
      FETCH:   state_d = redirect_bad ? ERROR : FETCH;
      ERROR:   state_d = ERROR;
      default: state_d = START;
    endcase
  end

  // Control decode. A redirect has priority over a load. A handshake that
  // coincides with a redirect still counts as a transfer. Redirects are
  // ignored in ERROR.
  always_comb begin
    transfer     = valid_q && instr_ready_in;
    redirect_ok  = 1'b0;
    redirect_bad = 1'b0;
    if (redirect_valid_in && (state_q != ERROR)) begin
      if (redirect_pc_in[1:0] == 2'b00) begin
        redirect_ok = 1'b1;
      end else begin
        redirect_bad = 1'b1;
      end
    end
    do_load = (state_q == FETCH) && !redirect_valid_in &&
              (!valid_q || instr_ready_in);
  end

  // Datapath. The PC, output slot, error flag and handshake counter are
  // updated here. During a stall nothing matches, so the slot and PC hold.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_q    <= RESET_PC;
      pcout_q <= '0;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      count_q <= 32'h0;
    end else begin
      if (transfer) begin
        count_q <= count_q + 32'd1;
      end
      if (redirect_bad) begin
        valid_q <= 1'b0;
        err_q   <= 1'b1;
      end else if (redirect_ok) begin
        pc_q    <= redirect_pc_in;
        valid_q <= 1'b0;
      end else if (do_load) begin
        instr_q <= rom_data_in;
        pcout_q <= pc_q;
        valid_q <= 1'b1;
        pc_q    <= pc_q + ADDR_WIDTH'(4);
      end else if (transfer) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rom_addr_out     = pc_q;
  assign instr_out        = instr_q;
  assign pc_out           = pcout_q;
  assign instr_valid_out  = valid_q;
  assign misalign_err_out = err_q;
  assign fetch_count_out  = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
//   Directed bench for instr_fetch. The ROM model returns {8'hA5, address},
//   so every fetched word carries its own address in the low 24 bits.
//   Inputs are driven 1 time unit after a rising edge. Outputs are sampled
//   at the same point, away from the edge.

module tb_instr_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [23:0] rom_addr_out;
  logic [31:0] rom_data_in;
  logic        redirect_valid_in;
  logic [23:0] redirect_pc_in;
  logic [31:0] instr_out;
  logic [23:0] pc_out;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic        misalign_err_out;
  logic [31:0] fetch_count_out;

  int checks = 0;
  int errors = 0;

  instr_fetch #(
    .ADDR_WIDTH(24),
    .RESET_PC  (24'h000000)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rom_addr_out     (rom_addr_out),
    .rom_data_in      (rom_data_in),
    .redirect_valid_in(redirect_valid_in),
    .redirect_pc_in   (redirect_pc_in),
    .instr_out        (instr_out),
    .pc_out           (pc_out),
    .instr_valid_out  (instr_valid_out),
    .instr_ready_in   (instr_ready_in),
    .misalign_err_out (misalign_err_out),
    .fetch_count_out  (fetch_count_out)
  );

  // Free-running clock with a period of 10 time units.
  always #5 clk_in = ~clk_in;

  // Combinational ROM model.
  assign rom_data_in = {8'hA5, rom_addr_out};

  // Compare one observed value with its expected value and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive all inputs, then advance to 1 time unit past the next rising edge.
  task automatic applyStimulus(input logic rst, input logic rv,
                               input logic [23:0] rpc, input logic rdy);
    rst_in            = rst;
    redirect_valid_in = rv;
    redirect_pc_in    = rpc;
    instr_ready_in    = rdy;
    @(posedge clk_in);
    #1;
  endtask

  // Check the slot content and confirm that its word matches its address.
  task automatic checkSlot(input string tag, input logic [23:0] exp_pc);
    checkOutput({tag, "_valid"}, {31'h0, instr_valid_out}, 32'h1);
    checkOutput({tag, "_pc"}, {8'h0, pc_out}, {8'h0, exp_pc});
    checkOutput({tag, "_instr"}, instr_out, {8'hA5, exp_pc});
  endtask

  initial begin
    rst_in            = 1'b1;
    redirect_valid_in = 1'b0;
    redirect_pc_in    = 24'h0;
    instr_ready_in    = 1'b0;
    #1;

    // Reset state.
    applyStimulus(1'b1, 1'b0, 24'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 24'h0, 1'b0);
    checkOutput("rst_valid", {31'h0, instr_valid_out}, 32'h0);
    checkOutput("rst_pc", {8'h0, pc_out}, 32'h0);
    checkOutput("rst_instr", instr_out, 32'h0);
    checkOutput("rst_err", {31'h0, misalign_err_out}, 32'h0);
    checkOutput("rst_count", fetch_count_out, 32'h0);
    checkOutput("rst_rom", {8'h0, rom_addr_out}, 32'h0);

    // The first edge after reset only leaves START.
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    checkOutput("start_valid", {31'h0, instr_valid_out}, 32'h0);

    // Streaming with ready high: one instruction per cycle.
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checkSlot($sformatf("stream%0d", i), 24'(i * 4));
      applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    end
    checkOutput("stream_count", fetch_count_out, 32'd6);

    // Stall: the slot and PC hold while ready is low.
    applyStimulus(1'b1, 1'b0, 24'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkSlot($sformatf("stall%0d", k), 24'h000000);
      checkOutput($sformatf("stall%0d_rom", k), {8'h0, rom_addr_out}, 32'h4);
      applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
    end
    checkOutput("stall_count", fetch_count_out, 32'd0);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    checkSlot("unstall", 24'h000004);
    checkOutput("unstall_count", fetch_count_out, 32'd1);

    // Redirect that coincides with the handshake of the slot at pc 8.
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    checkSlot("pre_redir", 24'h000008);
    applyStimulus(1'b0, 1'b1, 24'h000100, 1'b1);
    checkOutput("redir_flush", {31'h0, instr_valid_out}, 32'h0);
    checkOutput("redir_count", fetch_count_out, 32'd3);
    checkOutput("redir_rom", {8'h0, rom_addr_out}, 32'h100);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    checkSlot("redir_first", 24'h000100);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    checkSlot("redir_second", 24'h000104);
    checkOutput("redir_count2", fetch_count_out, 32'd4);

    // Misaligned redirect locks the unit into ERROR.
    applyStimulus(1'b0, 1'b1, 24'h000102, 1'b0);
    checkOutput("mis_err", {31'h0, misalign_err_out}, 32'h1);
    checkOutput("mis_valid", {31'h0, instr_valid_out}, 32'h0);
    checkOutput("mis_rom", {8'h0, rom_addr_out}, 32'h108);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    checkOutput("err_valid", {31'h0, instr_valid_out}, 32'h0);
    applyStimulus(1'b0, 1'b1, 24'h000200, 1'b1);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    checkOutput("err_ign_rom", {8'h0, rom_addr_out}, 32'h108);
    checkOutput("err_ign_valid", {31'h0, instr_valid_out}, 32'h0);
    checkOutput("err_ign_err", {31'h0, misalign_err_out}, 32'h1);
    checkOutput("err_count", fetch_count_out, 32'd4);

    // Reset clears the error, and fetch resumes at RESET_PC.
    applyStimulus(1'b1, 1'b0, 24'h0, 1'b1);
    checkOutput("clr_err", {31'h0, misalign_err_out}, 32'h0);
    checkOutput("clr_count", fetch_count_out, 32'd0);
    checkOutput("clr_rom", {8'h0, rom_addr_out}, 32'h0);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    checkSlot("clr_first", 24'h000000);

    // Address wrap past the top of the ROM.
    applyStimulus(1'b0, 1'b1, 24'hFFFFF8, 1'b1);
    checkOutput("wrap_flush", {31'h0, instr_valid_out}, 32'h0);
    checkOutput("wrap_rom", {8'h0, rom_addr_out}, 32'hFFFFF8);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    checkSlot("wrap0", 24'hFFFFF8);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    checkSlot("wrap1", 24'hFFFFFC);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    checkSlot("wrap2", 24'h000000);
    checkOutput("wrap_err", {31'h0, misalign_err_out}, 32'h0);
    checkOutput("wrap_count", fetch_count_out, 32'd3);

    // Redirect during START retargets the first fetch.
    applyStimulus(1'b1, 1'b0, 24'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 24'h000040, 1'b1);
    checkOutput("start_redir_rom", {8'h0, rom_addr_out}, 32'h40);
    checkOutput("start_redir_valid", {31'h0, instr_valid_out}, 32'h0);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    checkSlot("start_redir", 24'h000040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
